// File: rtl/horner_eval_arbiter.sv
// horner_eval_arbiter
// Shares one Horner-cubic evaluator between N_REQ AXI-stream requesters.
// Requests are granted round-robin. Only one evaluation is in flight at a
// time. Each result goes back tagged with the requester id, and a watchdog
// aborts an evaluation that never produces its final beat.
//
// Handshake semantics (all stream ports): a beat transfers on a rising clk
// edge where tvalid and tready are both high. A producer holds tvalid and
// its payload stable until that edge. The block never makes its own tvalid
// depend on the partner's tready.
module horner_eval_arbiter #(
  parameter int          N_REQ     = 4,
  parameter logic [63:0] KICK_WORD = 64'h3FF0000000000000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*64-1:0]      req_tdata,
  input  logic [N_REQ-1:0]         req_tvalid,
  output logic [N_REQ-1:0]         req_tready,
  output logic [63:0]              rsp_tdata,
  output logic [$clog2(N_REQ)-1:0] rsp_tid,
  output logic                     rsp_err,
  output logic                     rsp_tvalid,
  input  logic                     rsp_tready,
  output logic [63:0]              ev_x,
  output logic [63:0]              ev_s_tdata,
  output logic                     ev_s_tvalid,
  output logic                     ev_s_tlast,
  input  logic                     ev_s_tready,
  input  logic [63:0]              ev_m_tdata,
  input  logic                     ev_m_tvalid,
  input  logic                     ev_m_tlast,
  output logic                     ev_m_tready,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]     state_q;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] gid_q;
  logic [63:0]    x_q;
  logic [63:0]    rsp_tdata_q;
  logic           rsp_err_q;
  logic           rsp_tvalid_q;
  logic           ev_s_tvalid_q;
  logic           ev_m_tready_q;
  logic           busy_q;
  logic [TW-1:0]  timer_q;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic [63:0]    sel_x;

  // Round-robin search: first valid requester after last_grant_q, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % N_REQ);
      if (!win_found && req_tvalid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign sel_x = req_tdata[int'(win_id)*64 +: 64];

  // Ready goes only to the winner, and only while idle.
  always_comb begin
    req_tready = '0;
    if (state_q == S_IDLE && win_found) req_tready[win_id] = 1'b1;
  end

  // Main controller: grant, kick the evaluator, collect the result or time out,
  // then hold the response until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= IDW'(N_REQ - 1);
      gid_q         <= '0;
      x_q           <= '0;
      rsp_tdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_tvalid_q  <= 1'b0;
      ev_s_tvalid_q <= 1'b0;
      ev_m_tready_q <= 1'b0;
      busy_q        <= 1'b0;
      timer_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            x_q           <= sel_x;
            gid_q         <= win_id;
            ev_s_tvalid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ev_s_tready) begin
            ev_s_tvalid_q <= 1'b0;
            ev_m_tready_q <= 1'b1;
            timer_q       <= '0;
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          // A final beat in the timeout cycle still counts as a good result.
          if (ev_m_tvalid && ev_m_tlast) begin
            rsp_tdata_q   <= ev_m_tdata;
            rsp_err_q     <= 1'b0;
            rsp_tvalid_q  <= 1'b1;
            ev_m_tready_q <= 1'b0;
            state_q       <= S_RESP;
          end else if (timer_q == T_LAST) begin
            rsp_tdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_tvalid_q  <= 1'b1;
            ev_m_tready_q <= 1'b0;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_tready) begin
            rsp_tvalid_q <= 1'b0;
            last_grant_q <= gid_q;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ev_x        = x_q;
  assign ev_s_tdata  = KICK_WORD;
  assign ev_s_tvalid = ev_s_tvalid_q;
  assign ev_s_tlast  = ev_s_tvalid_q;
  assign ev_m_tready = ev_m_tready_q;
  assign rsp_tdata   = rsp_tdata_q;
  assign rsp_tid     = gid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_tvalid  = rsp_tvalid_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule
